// File: rtl/eth_udp_extract.sv
// ----------------------------------------------------------------------------
// eth_udp_extract : Ethernet/IPv4/UDP header parser, emits payload of UDP
//                   datagrams addressed to UDP_PORT with SOP/EOP/ABORT framing.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eth_udp_extract #(
  parameter logic [15:0] UDP_PORT = 16'd5000,
  parameter bit          CHK_IP   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  IN_ETH_STREAM,
  output logic [7:0]  OUT_DAT,
  output logic        OUT_VLD,
  output logic        OUT_SOP,
  output logic        OUT_EOP,
  output logic        OUT_ABORT,
  output logic [15:0] PKT_CNT,
  output logic [15:0] DROP_CNT
);

  typedef enum logic [2:0] {
    S_GAP   = 3'd0,
    S_IDLE  = 3'd1,
    S_HDR   = 3'd2,
    S_PAY   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [5:0] C_OFF_MAX = 6'd42;

  logic       w_cke;
  logic       w_frm;
  logic [7:0] w_dat;
  assign w_cke = IN_ETH_STREAM[9];
  assign w_frm = IN_ETH_STREAM[8];
  assign w_dat = IN_ETH_STREAM[7:0];

  state_t      state_q, state_d;
  logic [5:0]  off_q, off_d;
  logic [7:0]  ulen_hi_q, ulen_hi_d;
  logic [15:0] rem_q, rem_d;
  logic        first_q, first_d;
  logic [7:0]  dat_q, dat_d;
  logic        vld_q, vld_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        abort_q, abort_d;
  logic [15:0] pkt_q, pkt_d;
  logic [15:0] drop_q, drop_d;

  logic        w_pkt_inc;
  logic        w_drop_inc;
  logic        w_hdr_bad;
  logic [15:0] w_ulen;

  assign w_ulen = {ulen_hi_q, w_dat};

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    ulen_hi_d  = ulen_hi_q;
    rem_d      = rem_q;
    first_d    = first_q;
    dat_d      = dat_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    abort_d    = 1'b0;
    w_pkt_inc  = 1'b0;
    w_drop_inc = 1'b0;
    w_hdr_bad  = 1'b0;

    if (w_cke) begin
      case (state_q)
        S_GAP: begin
          if (!w_frm) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (w_frm) begin
            off_d   = 6'd1;
            state_d = S_HDR;
          end
        end
        S_HDR: begin
          if (!w_frm) begin
            w_drop_inc = 1'b1;
            state_d    = S_IDLE;
          end else begin
            off_d = (off_q == C_OFF_MAX) ? C_OFF_MAX : off_q + 6'd1;
            case (off_q)
              6'd12: w_hdr_bad = (w_dat != 8'h08);
              6'd13: w_hdr_bad = (w_dat != 8'h00);
              6'd14: w_hdr_bad = CHK_IP && (w_dat != 8'h45);
              6'd23: w_hdr_bad = (w_dat != 8'h11);
              6'd36: w_hdr_bad = (w_dat != UDP_PORT[15:8]);
              6'd37: w_hdr_bad = (w_dat != UDP_PORT[7:0]);
              6'd38: ulen_hi_d = w_dat;
              6'd39: begin
                // A UDP length of 8 or less carries no payload to deliver.
                w_hdr_bad = (w_ulen <= 16'd8);
                rem_d     = w_ulen - 16'd8;
              end
              default: ;
            endcase
            if (w_hdr_bad) begin
              w_drop_inc = 1'b1;
              state_d    = S_DRAIN;
            end else if (off_q == 6'd41) begin
              first_d = 1'b1;
              state_d = S_PAY;
            end
          end
        end
        S_PAY: begin
          if (!w_frm) begin
            abort_d    = 1'b1;
            w_drop_inc = 1'b1;
            state_d    = S_IDLE;
          end else begin
            vld_d   = 1'b1;
            dat_d   = w_dat;
            sop_d   = first_q;
            first_d = 1'b0;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              eop_d     = 1'b1;
              w_pkt_inc = 1'b1;
              state_d   = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!w_frm) state_d = S_IDLE;
        end
        default: state_d = S_GAP;
      endcase
    end

    pkt_d  = (w_pkt_inc  && (pkt_q  != 16'hFFFF)) ? pkt_q  + 16'd1 : pkt_q;
    drop_d = (w_drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_GAP;
      off_q     <= 6'd0;
      ulen_hi_q <= 8'd0;
      rem_q     <= 16'd0;
      first_q   <= 1'b0;
      dat_q     <= 8'd0;
      vld_q     <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      abort_q   <= 1'b0;
      pkt_q     <= 16'd0;
      drop_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      ulen_hi_q <= ulen_hi_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      abort_q   <= abort_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
    end
  end

  assign OUT_DAT   = dat_q;
  assign OUT_VLD   = vld_q;
  assign OUT_SOP   = sop_q;
  assign OUT_EOP   = eop_q;
  assign OUT_ABORT = abort_q;
  assign PKT_CNT   = pkt_q;
  assign DROP_CNT  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_udp_extract.sv
// ----------------------------------------------------------------------------
// tb_eth_udp_extract : directed frames with a queued expected-payload scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_eth_udp_extract;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  IN_ETH_STREAM = 10'd0;
  logic [7:0]  OUT_DAT;
  logic        OUT_VLD;
  logic        OUT_SOP;
  logic        OUT_EOP;
  logic        OUT_ABORT;
  logic [15:0] PKT_CNT;
  logic [15:0] DROP_CNT;

  eth_udp_extract #(.UDP_PORT(16'd5000), .CHK_IP(1'b1)) dut (
    .CLK(CLK), .RST(RST), .IN_ETH_STREAM(IN_ETH_STREAM),
    .OUT_DAT(OUT_DAT), .OUT_VLD(OUT_VLD), .OUT_SOP(OUT_SOP), .OUT_EOP(OUT_EOP),
    .OUT_ABORT(OUT_ABORT), .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       abort;
    logic       sop;
    logic       eop;
    logic [7:0] dat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fr[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_pkt = 0;
  int         exp_drop = 0;
  logic       cke_at_edge = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge CLK) cke_at_edge <= IN_ETH_STREAM[9];

  // Monitor: every output event must match the head of the expected queue.
  always @(negedge CLK) begin
    if (OUT_VLD || OUT_ABORT) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {OUT_VLD, OUT_ABORT, OUT_SOP, OUT_EOP, OUT_DAT}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.abort) begin
          check("abort_event", {OUT_VLD, OUT_ABORT, OUT_SOP, OUT_EOP}, 32'b0100);
        end else begin
          check("payload_byte", {OUT_VLD, OUT_ABORT, OUT_SOP, OUT_EOP, OUT_DAT},
                {1'b1, 1'b0, e.sop, e.eop, e.dat});
          check("vld_follows_cke", {31'd0, cke_at_edge}, 32'd1);
        end
      end
    end
  end

  task automatic drive(input logic cke, input logic frm, input logic [7:0] d);
    @(negedge CLK);
    IN_ETH_STREAM = {cke, frm, d};
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input int div, input int from, input int to);
    for (int i = from; i < to; i++) begin
      for (int k = 0; k < div - 1; k++) drive(1'b0, 1'b1, 8'hEE);
      drive(1'b1, 1'b1, fr[i]);
    end
  endtask

  task automatic build(input logic [15:0] port, input logic [15:0] etype,
                       input logic [15:0] ulen, input int npay,
                       input logic [7:0] pbase, input int total);
    fr.delete();
    for (int i = 0; i < 12; i++) fr.push_back(8'(8'h10 + i));
    fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
    fr.push_back(8'h45); fr.push_back(8'h00);
    for (int i = 0; i < 6; i++) fr.push_back(8'h00);
    fr.push_back(8'h40); fr.push_back(8'h11);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < 8; i++) fr.push_back(8'(8'hC0 + i));
    fr.push_back(8'h12); fr.push_back(8'h34);
    fr.push_back(port[15:8]); fr.push_back(port[7:0]);
    fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
    fr.push_back(8'h00); fr.push_back(8'h00);
    for (int i = 0; i < npay; i++) fr.push_back(8'(pbase + 8'h11 * i));
    while (fr.size() < total) fr.push_back(8'h00);
    fr.push_back(8'hDE); fr.push_back(8'hAD); fr.push_back(8'hBE); fr.push_back(8'hEF);
  endtask

  task automatic expect_pay(input int n, input logic [7:0] pbase, input logic full, input logic abort);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.abort = 1'b0;
      e.sop   = (i == 0);
      e.eop   = full && (i == n - 1);
      e.dat   = 8'(pbase + 8'h11 * i);
      exp_q.push_back(e);
    end
    if (abort) begin
      e = '0;
      e.abort = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic settle_and_count(input string tag);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    check({tag, "_pkt_cnt"},  {16'd0, PKT_CNT},  exp_pkt);
    check({tag, "_drop_cnt"}, {16'd0, DROP_CNT}, exp_drop);
  endtask

  task automatic good_frame(input int div, input string tag);
    build(16'd5000, 16'h0800, 16'd12, 4, 8'h11, 0);
    expect_pay(4, 8'h11, 1'b1, 1'b0);
    send(div, 0, fr.size());
    end_frame();
    exp_pkt++;
    settle_and_count(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_outputs", {OUT_VLD, OUT_SOP, OUT_EOP, OUT_ABORT, OUT_DAT}, 32'h0);
    check("reset_counters", {PKT_CNT, DROP_CNT}, 32'h0);
    RST = 1'b0;
    end_frame();

    // 1: basic delivery
    good_frame(1, "t1");

    // 2: wrong port, wrong EtherType, then a good frame
    build(16'd5001, 16'h0800, 16'd12, 4, 8'h11, 0);
    send(1, 0, fr.size()); end_frame(); exp_drop++;
    build(16'd5000, 16'h86DD, 16'd12, 4, 8'h11, 0);
    send(1, 0, fr.size()); end_frame(); exp_drop++;
    settle_and_count("t2_drop");
    good_frame(1, "t2_good");

    // 3: sparse CKE
    good_frame(4, "t3");

    // 4: truncated datagram
    build(16'd5000, 16'h0800, 16'd100, 10, 8'h01, 0);
    expect_pay(10, 8'h01, 1'b0, 1'b1);
    send(1, 0, 52); end_frame(); exp_drop++;
    settle_and_count("t4");

    // 5: one-byte payload in a padded minimum frame, then ulen=8
    build(16'd5000, 16'h0800, 16'd9, 1, 8'hA5, 60);
    expect_pay(1, 8'hA5, 1'b1, 1'b0);
    send(1, 0, fr.size()); end_frame(); exp_pkt++;
    settle_and_count("t5_one");
    build(16'd5000, 16'h0800, 16'd8, 0, 8'h00, 60);
    send(1, 0, fr.size()); end_frame(); exp_drop++;
    settle_and_count("t5_ulen8");

    // 6: reset in the middle of the payload
    build(16'd5000, 16'h0800, 16'd12, 4, 8'h11, 0);
    expect_pay(2, 8'h11, 1'b0, 1'b0);
    send(1, 0, 44);
    @(negedge CLK);
    RST = 1'b1;
    IN_ETH_STREAM = {1'b1, 1'b1, fr[44]};
    drive(1'b1, 1'b1, fr[45]);
    @(negedge CLK);
    check("t6_reset_outputs", {OUT_VLD, OUT_SOP, OUT_EOP, OUT_ABORT}, 32'h0);
    check("t6_reset_counters", {PKT_CNT, DROP_CNT}, 32'h0);
    exp_pkt = 0; exp_drop = 0;
    RST = 1'b0;
    IN_ETH_STREAM = {1'b1, 1'b1, fr[46]};
    send(1, 47, fr.size()); end_frame();
    settle_and_count("t6_skip");
    good_frame(1, "t6_after");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
